vector_store_serializer: RTL

- Write-side counterpart of the writeback path's memory read.
- Takes a full vector (vecSize lanes of registerSize bits) from the pipeline and a base address, then writes it lane by lane to a single-lane data-memory write port.
- Each beat is handshaked with a memory ready signal, and individual lanes can be masked off.
- Sits between the execute/memory stage and data memory; its `busy` signal stalls the pipeline.

---
 rtl/asip_store_pkg.sv | 26 ++
 rtl/next_lane_finder.sv | 39 +++
 rtl/vector_store_serializer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/asip_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : asip_store_pkg
//  Purpose  : Shared types and helpers for the vector store serializer:
//             the controller state encoding and the lane-index width helper.
//  Ports    : (package - no ports)
//  Revision : 1.0  initial release
// ============================================================================
package asip_store_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Lane-index width. A one-lane vector still gets a 1-bit index so that
    // no zero-width vectors appear anywhere.
    function automatic int lane_idx_width(input int vec_size);
        int w;
        w = $clog2(vec_size);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_lane_finder.sv
`default_nettype none
// ============================================================================
//  Module   : next_lane_finder
//  Purpose  : Combinational priority encoder returning the lowest set mask
//             bit. With from_start=1 the whole mask is searched; otherwise
//             only lanes strictly above cur_lane are considered.
//  Ports    : mask       - lane enable mask
//             cur_lane   - lane just completed (ignored when from_start=1)
//             from_start - search from lane 0
//             next_lane  - index of the selected lane (0 when none)
//             valid      - a qualifying lane exists
//  Revision : 1.0  initial release
// ============================================================================
module next_lane_finder #(
    parameter int VEC_SIZE = 4,
    parameter int LANE_W   = 2
) (
    input  logic [VEC_SIZE-1:0] mask,
    input  logic [LANE_W-1:0]   cur_lane,
    input  logic                from_start,
    output logic [LANE_W-1:0]   next_lane,
    output logic                valid
);

    // Scan from the top down so the lowest qualifying lane is written last
    // and therefore wins.
    always_comb begin
        next_lane = '0;
        valid     = 1'b0;
        for (int i = VEC_SIZE - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur_lane)))) begin
                next_lane = LANE_W'(i);
                valid     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vector_store_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : vector_store_serializer
//  Purpose  : Captures a full vector plus base address and writes it lane by
//             lane, in ascending lane order, to a single-lane memory write
//             port. Masked-off lanes are skipped with no idle cycles.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             start               - store request (accepted when busy=0)
//             address             - base address; lane i goes to address+i
//             writeData, laneMask - vector and lane enables, captured on start
//             mem_ready           - memory accepts the current beat
//             busy                - transfer in progress, stalls upstream
//             done                - one-cycle completion pulse
//             mem_we/addr/wdata   - memory beat
//  Revision : 1.0  initial release
// ============================================================================
module vector_store_serializer #(
    parameter int VEC_SIZE      = 4,
    parameter int REGISTER_SIZE = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [REGISTER_SIZE-1:0]               address,
    input  logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0] writeData,
    input  logic [VEC_SIZE-1:0]                    laneMask,
    input  logic                                   mem_ready,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   mem_we,
    output logic [REGISTER_SIZE-1:0]               mem_addr,
    output logic [REGISTER_SIZE-1:0]               mem_wdata
);

    import asip_store_pkg::*;

    localparam int LANE_W = lane_idx_width(VEC_SIZE);

    state_t                                 state_q, state_d;
    logic [VEC_SIZE-1:0][REGISTER_SIZE-1:0] data_q,  data_d;
    logic [VEC_SIZE-1:0]                    mask_q,  mask_d;
    logic [REGISTER_SIZE-1:0]               base_q,  base_d;
    logic [LANE_W-1:0]                      lane_q,  lane_d;

    logic [VEC_SIZE-1:0] find_mask;
    logic                find_from_start;
    logic [LANE_W-1:0]   find_lane;
    logic                find_valid;

    // One encoder serves both searches: in SEND it looks past the current
    // lane of the captured mask; otherwise it scans the incoming mask from
    // lane 0 so an accepted start lands directly on the first enabled lane.
    assign find_mask       = (state_q == ST_SEND) ? mask_q : laneMask;
    assign find_from_start = (state_q != ST_SEND);

    next_lane_finder #(
        .VEC_SIZE (VEC_SIZE),
        .LANE_W   (LANE_W)
    ) u_next_lane_finder (
        .mask       (find_mask),
        .cur_lane   (lane_q),
        .from_start (find_from_start),
        .next_lane  (find_lane),
        .valid      (find_valid)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        base_d  = base_q;
        lane_d  = lane_q;
        case (state_q)
            ST_SEND: begin
                // mem_we is constant high here, so ready alone completes a beat
                if (mem_ready) begin
                    if (find_valid) begin
                        lane_d = find_lane;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            default: begin
                // IDLE and FINISH both accept; FINISH otherwise drops to IDLE
                state_d = ST_IDLE;
                if (start) begin
                    data_d  = writeData;
                    mask_d  = laneMask;
                    base_d  = address;
                    lane_d  = find_valid ? find_lane : '0;
                    state_d = find_valid ? ST_SEND : ST_FINISH;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            mask_q  <= '0;
            base_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            base_q  <= base_d;
            lane_q  <= lane_d;
        end
    end

    // All outputs decode registered state only, so they cannot move while
    // a beat is stalled on mem_ready. The address add wraps naturally.
    assign busy      = (state_q == ST_SEND);
    assign mem_we    = (state_q == ST_SEND);
    assign done      = (state_q == ST_FINISH);
    assign mem_addr  = base_q + REGISTER_SIZE'(lane_q);
    assign mem_wdata = data_q[lane_q];

endmodule
`default_nettype wire
